// File: rtl/spi_pix_pkg.sv
// Shared definitions for the SPI pixel frame receiver.
//   state_t           frame FSM encoding
//   SYNC0/1_DEF       default start sequence bytes
//   STOP_BYTE_DEF     default stop byte (sent twice)
//   SCLK_MIN_HALF_NS  shortest legal SCLK high or low time; below this the
//                     2-FF synchroniser on clk_sys can miss an edge
package spi_pix_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SYNC_A = 3'd1,
      ST_SYNC_B = 3'd2,
      ST_PIXEL  = 3'd3,
      ST_HUNT   = 3'd4
   } state_t;

   localparam logic [7:0] SYNC0_DEF     = 8'h55;
   localparam logic [7:0] SYNC1_DEF     = 8'h5B;
   localparam logic [7:0] STOP_BYTE_DEF = 8'hAA;

   localparam int SCLK_MIN_HALF_NS = 40;

endpackage

// File: rtl/spi_byte_deser.sv
// SPI slave byte deserialiser (mode 3: SCLK idles high, sample on rise, MSB first).
// Ports:
//   i_clk, i_rst      system clock, synchronous active-high reset
//   i_sclk/i_cs/i_mosi asynchronous SPI pins
//   o_byte_vld        one-cycle strobe, o_byte holds the completed byte
//   o_cs_fall         one-cycle pulse on synchronised CS falling edge
//   o_cs_rise         one-cycle pulse on synchronised CS rising edge
//   o_partial         bit counter is non-zero (byte in progress)
module spi_byte_deser
   import spi_pix_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_sclk,
   input  logic       i_cs,
   input  logic       i_mosi,
   output logic       o_byte_vld,
   output logic [7:0] o_byte,
   output logic       o_cs_fall,
   output logic       o_cs_rise,
   output logic       o_partial
);

   // [0],[1] synchroniser stages, [2] previous value for edge detection
   logic [2:0] r_sclk_sync;
   logic [2:0] r_cs_sync;
   logic [1:0] r_mosi_sync;
   logic [2:0] r_bit_cnt;
   logic [6:0] r_shift;
   logic       w_sclk_rise;

   assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
   assign o_cs_fall   = r_cs_sync[2] & ~r_cs_sync[1];
   assign o_cs_rise   = ~r_cs_sync[2] & r_cs_sync[1];
   assign o_partial   = (r_bit_cnt != 3'd0);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         // SCLK resets to its idle level so no false rise appears.
         // CS resets low: if reset hits mid-frame with CS still asserted,
         // no CS fall is seen afterwards and the rest of that frame is ignored.
         r_sclk_sync <= 3'b111;
         r_cs_sync   <= 3'b000;
         r_mosi_sync <= 2'b00;
         r_bit_cnt   <= 3'd0;
         r_shift     <= 7'd0;
         o_byte_vld  <= 1'b0;
         o_byte      <= 8'd0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[1:0], i_sclk};
         r_cs_sync   <= {r_cs_sync[1:0], i_cs};
         r_mosi_sync <= {r_mosi_sync[0], i_mosi};
         o_byte_vld  <= 1'b0;
         if (r_cs_sync[1]) begin
            r_bit_cnt <= 3'd0;
         end else if (w_sclk_rise) begin
            r_shift   <= {r_shift[5:0], r_mosi_sync[1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
               o_byte_vld <= 1'b1;
               o_byte     <= {r_shift, r_mosi_sync[1]};
            end
         end
      end
   end

endmodule

// File: rtl/spi_pixel_frame_rx.sv
// SPI pixel frame receiver: checks start bytes, assembles pixels, writes them
// to pixel RAM by index and validates the stop sequence at CS release.
// Ports:
//   i_clk50m, i_rst          system clock, synchronous active-high reset
//   i_sclk, i_cs, i_mosi     asynchronous SPI slave pins
//   o_wr_en/addr/data        one-cycle pixel RAM write, first byte in MSBs
//   o_busy                   frame in progress (CS low)
//   o_frame_done/o_frame_err one-cycle accept/reject pulses
//   o_pixel_count            pixel count of last accepted frame
// Optional: define SPI_PIX_CHECKSUM_EN to expect an XOR checksum byte of all
// pixel bytes just before the stop sequence.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | CS high, waiting for CS fall
// ST_SYNC_A | expecting first start byte
// ST_SYNC_B | expecting second start byte
// ST_PIXEL  | receiving pixel data through the delay line
// ST_HUNT   | bad start, ignore bytes until CS rises
module spi_pixel_frame_rx
   import spi_pix_pkg::*;
#(
   parameter int         BYTES_PER_PIXEL = 3,
   parameter int         MAX_PIXELS      = 1200,
   parameter int         ADDR_W          = 11,
   parameter logic [7:0] SYNC0           = SYNC0_DEF,
   parameter logic [7:0] SYNC1           = SYNC1_DEF,
   parameter logic [7:0] STOP_BYTE       = STOP_BYTE_DEF
)
(
   input  logic                         i_clk50m,
   input  logic                         i_rst,
   input  logic                         i_sclk,
   input  logic                         i_cs,
   input  logic                         i_mosi,
   output logic                         o_wr_en,
   output logic [ADDR_W-1:0]            o_wr_addr,
   output logic [8*BYTES_PER_PIXEL-1:0] o_wr_data,
   output logic                         o_busy,
   output logic                         o_frame_done,
   output logic                         o_frame_err,
   output logic [ADDR_W:0]              o_pixel_count
);

   localparam int PIX_W = 8 * BYTES_PER_PIXEL;
`ifdef SPI_PIX_CHECKSUM_EN
   localparam int DL_DEPTH = 3;
`else
   localparam int DL_DEPTH = 2;
`endif
   localparam logic [1:0]      DL_FULL  = 2'(DL_DEPTH);
   localparam logic [2:0]      ASM_LAST = 3'(BYTES_PER_PIXEL - 1);
   localparam logic [ADDR_W:0] MAX_IDX  = (ADDR_W + 1)'(MAX_PIXELS);

   logic       w_byte_vld;
   logic [7:0] w_byte;
   logic       w_cs_fall;
   logic       w_cs_rise;
   logic       w_partial;

   spi_byte_deser u_deser (
      .i_clk      (i_clk50m),
      .i_rst      (i_rst),
      .i_sclk     (i_sclk),
      .i_cs       (i_cs),
      .i_mosi     (i_mosi),
      .o_byte_vld (w_byte_vld),
      .o_byte     (w_byte),
      .o_cs_fall  (w_cs_fall),
      .o_cs_rise  (w_cs_rise),
      .o_partial  (w_partial)
   );

   state_t                      r_state, w_next;
   logic [DL_DEPTH-1:0][7:0]    r_dl;       // [0] newest byte
   logic [1:0]                  r_dl_cnt;
   logic [2:0]                  r_asm_cnt;
   logic [PIX_W-1:0]            r_asm_data;
   logic [ADDR_W:0]             r_idx;
   logic                        r_ovf;
   logic                        r_any_byte;
   logic                        w_done, w_err, w_accept, w_csum_ok;
   logic [7:0]                  w_pix_byte;
   logic [PIX_W-1:0]            w_pix;

   // The assembler register doubles as the write data: the next pixel byte
   // arrives many clocks after the write strobe, so it is stable when used.
   assign o_wr_data  = r_asm_data;
   assign w_pix_byte = r_dl[DL_DEPTH-1];

   if (PIX_W > 8) begin : g_asm_wide
      assign w_pix = {r_asm_data[PIX_W-9:0], w_pix_byte};
   end else begin : g_asm_narrow
      assign w_pix = w_pix_byte;
   end

`ifdef SPI_PIX_CHECKSUM_EN
   logic [7:0] r_csum;
   assign w_csum_ok = (r_dl[2] == r_csum);
`else
   assign w_csum_ok = 1'b1;
`endif

   assign w_accept = !w_partial && (r_dl_cnt == DL_FULL) &&
                     (r_dl[1] == STOP_BYTE) && (r_dl[0] == STOP_BYTE) &&
                     (r_asm_cnt == 3'd0) && !r_ovf && w_csum_ok;

   assign o_busy = (r_state != ST_IDLE) && !w_cs_rise;

   always_comb begin
      w_next = r_state;
      w_done = 1'b0;
      w_err  = 1'b0;
      if (w_cs_rise) begin
         w_next = ST_IDLE;
         case (r_state)
            ST_PIXEL: begin
               w_done = w_accept;
               w_err  = !w_accept;
            end
            ST_SYNC_A, ST_SYNC_B, ST_HUNT: w_err = r_any_byte;
            default: ;
         endcase
      end else begin
         case (r_state)
            ST_IDLE:   if (w_cs_fall)  w_next = ST_SYNC_A;
            ST_SYNC_A: if (w_byte_vld) w_next = (w_byte == SYNC0) ? ST_SYNC_B : ST_HUNT;
            ST_SYNC_B: if (w_byte_vld) w_next = (w_byte == SYNC1) ? ST_PIXEL : ST_HUNT;
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk50m) begin
      if (i_rst) begin
         r_state       <= ST_IDLE;
         r_dl          <= '0;
         r_dl_cnt      <= 2'd0;
         r_asm_cnt     <= 3'd0;
         r_asm_data    <= '0;
         r_idx         <= '0;
         r_ovf         <= 1'b0;
         r_any_byte    <= 1'b0;
         o_wr_en       <= 1'b0;
         o_wr_addr     <= '0;
         o_frame_done  <= 1'b0;
         o_frame_err   <= 1'b0;
         o_pixel_count <= '0;
`ifdef SPI_PIX_CHECKSUM_EN
         r_csum        <= 8'd0;
`endif
      end else begin
         r_state      <= w_next;
         o_frame_done <= w_done;
         o_frame_err  <= w_err;
         o_wr_en      <= 1'b0;
         if (w_done) o_pixel_count <= r_idx;
         if (w_cs_fall) begin
            r_dl_cnt   <= 2'd0;
            r_asm_cnt  <= 3'd0;
            r_idx      <= '0;
            r_ovf      <= 1'b0;
            r_any_byte <= 1'b0;
`ifdef SPI_PIX_CHECKSUM_EN
            r_csum     <= 8'd0;
`endif
         end else if (w_byte_vld && (r_state != ST_IDLE)) begin
            r_any_byte <= 1'b1;
            if (r_state == ST_PIXEL) begin
               r_dl <= {r_dl[DL_DEPTH-2:0], w_byte};
               if (r_dl_cnt != DL_FULL) begin
                  r_dl_cnt <= r_dl_cnt + 2'd1;
               end else begin
                  // oldest delayed byte is confirmed pixel data
                  r_asm_data <= w_pix;
`ifdef SPI_PIX_CHECKSUM_EN
                  r_csum     <= r_csum ^ w_pix_byte;
`endif
                  if (r_asm_cnt == ASM_LAST) begin
                     r_asm_cnt <= 3'd0;
                     if (r_idx < MAX_IDX) begin
                        o_wr_en   <= 1'b1;
                        o_wr_addr <= r_idx[ADDR_W-1:0];
                        r_idx     <= r_idx + 1'b1;
                     end else begin
                        r_ovf <= 1'b1;
                     end
                  end else begin
                     r_asm_cnt <= r_asm_cnt + 3'd1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_pixel_frame_rx.sv
module tb_spi_pixel_frame_rx;
   import spi_pix_pkg::*;

   localparam int BPP  = 3;
   localparam int MAXP = 20;
   localparam int AW   = 5;
   localparam int PW   = 8 * BPP;
   localparam int HALF = 3 * SCLK_MIN_HALF_NS / 2;
`ifdef SPI_PIX_CHECKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif

   typedef logic [7:0] u8;

   logic          clk, rst, sclk, cs, mosi;
   logic          o_wr_en, o_busy, o_frame_done, o_frame_err;
   logic [AW-1:0] o_wr_addr;
   logic [PW-1:0] o_wr_data;
   logic [AW:0]   o_pixel_count;

   spi_pixel_frame_rx #(.BYTES_PER_PIXEL(BPP), .MAX_PIXELS(MAXP), .ADDR_W(AW)) dut (
      .i_clk50m      (clk),
      .i_rst         (rst),
      .i_sclk        (sclk),
      .i_cs          (cs),
      .i_mosi        (mosi),
      .o_wr_en       (o_wr_en),
      .o_wr_addr     (o_wr_addr),
      .o_wr_data     (o_wr_data),
      .o_busy        (o_busy),
      .o_frame_done  (o_frame_done),
      .o_frame_err   (o_frame_err),
      .o_pixel_count (o_pixel_count)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // observed
   logic [AW-1:0] obs_addr[$];
   logic [PW-1:0] obs_data[$];
   int            n_done, n_err;
   // expected
   logic [AW-1:0] exp_addr[$];
   logic [PW-1:0] exp_data[$];
   int            exp_done, exp_err;
   logic [AW:0]   exp_count;

   u8 frm[$];

   always @(negedge clk) begin
      if (!rst) begin
         if (o_wr_en) begin
            obs_addr.push_back(o_wr_addr);
            obs_data.push_back(o_wr_data);
         end
         if (o_frame_done) n_done++;
         if (o_frame_err)  n_err++;
      end
   end

   // Reference: what a frame should produce, from the byte list alone.
   task automatic model_frame();
      int n, m, pb, np;
      bit ok;
      u8 x;
      logic [31:0] d;
      n = frm.size();
      exp_addr.delete(); exp_data.delete();
      exp_done = 0; exp_err = 0; ok = 0;
      if (n == 0) return;
      if (n < 2 || frm[0] != 8'h55 || frm[1] != 8'h5B) begin
         exp_err = 1;
         return;
      end
      m = n - 2;
      if (m >= 2 + CK) begin
         pb = m - 2 - CK;
         np = pb / BPP;
         for (int i = 0; i < np && i < MAXP; i++) begin
            d = 0;
            for (int j = 0; j < BPP; j++) d = {d[23:0], frm[2 + i*BPP + j]};
            exp_addr.push_back(AW'(i));
            exp_data.push_back(d[PW-1:0]);
         end
         ok = (frm[n-1] == 8'hAA) && (frm[n-2] == 8'hAA) && (pb % BPP == 0) && (np <= MAXP);
         if (CK != 0) begin
            x = 8'h00;
            for (int k = 0; k < pb; k++) x ^= frm[2 + k];
            ok = ok && (frm[n-3] == x);
         end
         if (ok) exp_count = (AW+1)'(np);
      end
      exp_done = ok ? 1 : 0;
      exp_err  = ok ? 0 : 1;
   endtask

   function automatic int wr_diff();
      if (obs_addr.size() != exp_addr.size()) return -2;
      foreach (exp_addr[i])
         if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) return i;
      return -1;
   endfunction

   task automatic append_tail();
      u8 x;
      if (CK != 0) begin
         x = 8'h00;
         for (int k = 2; k < frm.size(); k++) x ^= frm[k];
         frm.push_back(x);
      end
      frm.push_back(8'hAA);
      frm.push_back(8'hAA);
   endtask

   task automatic build_frame(input int npix, input bit fixed, input logic [PW-1:0] pix);
      frm.delete();
      frm.push_back(8'h55);
      frm.push_back(8'h5B);
      for (int i = 0; i < npix; i++)
         for (int j = 0; j < BPP; j++)
            frm.push_back(fixed ? pix[PW-1-8*j -: 8] : u8'($urandom));
      append_tail();
   endtask

   task automatic send_bits(input u8 b, input int nb);
      for (int i = 7; i > 7 - nb; i--) begin
         sclk = 1'b0; mosi = b[i]; #HALF;
         sclk = 1'b1; #HALF;
      end
   endtask

   task automatic clear_obs();
      obs_addr.delete(); obs_data.delete();
      n_done = 0; n_err = 0;
   endtask

   task automatic frame_open();  cs = 1'b0; #200; endtask
   task automatic frame_send();  foreach (frm[k]) send_bits(frm[k], 8); endtask
   task automatic frame_close(); #200; cs = 1'b1; #400; endtask

   task automatic run_frame();
      clear_obs();
      model_frame();
      frame_open();
      frame_send();
      frame_close();
   endtask

   task automatic test_reset();
      rst = 1'b1; cs = 1'b1; sclk = 1'b1; mosi = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      n_checks++;
      if ({o_wr_en, o_busy, o_frame_done, o_frame_err} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_flags got=%b want=0000", {o_wr_en, o_busy, o_frame_done, o_frame_err});
      end
      n_checks++;
      if (o_pixel_count !== '0 || o_wr_addr !== '0 || o_wr_data !== '0) begin
         n_fail++;
         $display("FAIL reset_data count=%0d addr=%0d data=%h want 0", o_pixel_count, o_wr_addr, o_wr_data);
      end
      rst = 1'b0;
      exp_count = '0;
      repeat (5) @(posedge clk);
   endtask

   task automatic test_basic();
      frm = '{8'h55, 8'h5B, 8'hFF, 8'h7D, 8'h00, 8'h00, 8'hFF, 8'h7D, 8'h7D, 8'h00, 8'hFF};
      append_tail();
      clear_obs();
      model_frame();
      frame_open();
      n_checks++;
      if (o_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_hi got=%b want=1", o_busy); end
      frame_send();
      frame_close();
      n_checks++;
      if (o_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_lo got=%b want=0", o_busy); end
      n_checks++;
      if (obs_data.size() != 3 || obs_addr[2] !== AW'(2) || obs_data[0] !== 24'hFF7D00 ||
          obs_data[1] !== 24'h00FF7D || obs_data[2] !== 24'h7D00FF) begin
         n_fail++;
         $display("FAIL basic_writes got n=%0d want 3 writes FF7D00 00FF7D 7D00FF", obs_data.size());
      end
      n_checks++;
      if (wr_diff() !== -1) begin n_fail++; $display("FAIL basic_model diff_at=%0d", wr_diff()); end
      n_checks++;
      if (n_done !== 1 || n_err !== 0) begin
         n_fail++; $display("FAIL basic_pulse done=%0d err=%0d want 1/0", n_done, n_err);
      end
      n_checks++;
      if (o_pixel_count !== 3) begin n_fail++; $display("FAIL basic_count got=%0d want=3", o_pixel_count); end
   endtask

   task automatic test_full();
      build_frame(MAXP, 1'b1, 24'h370000);
      run_frame();
      n_checks++;
      if (obs_addr.size() != MAXP || obs_addr[MAXP-1] !== AW'(MAXP-1) || wr_diff() !== -1) begin
         n_fail++; $display("FAIL full_writes n=%0d want=%0d", obs_addr.size(), MAXP);
      end
      n_checks++;
      if (n_done !== 1 || n_err !== 0 || o_pixel_count !== (AW+1)'(MAXP)) begin
         n_fail++; $display("FAIL full_done done=%0d err=%0d count=%0d", n_done, n_err, o_pixel_count);
      end
   endtask

   task automatic test_overflow();
      build_frame(MAXP + 1, 1'b1, 24'h370000);
      run_frame();
      n_checks++;
      if (obs_addr.size() != MAXP || wr_diff() !== -1) begin
         n_fail++; $display("FAIL ovf_writes n=%0d want=%0d", obs_addr.size(), MAXP);
      end
      n_checks++;
      if (n_done !== 0 || n_err !== 1 || o_pixel_count !== (AW+1)'(MAXP) || o_pixel_count !== exp_count) begin
         n_fail++; $display("FAIL ovf_err done=%0d err=%0d count=%0d", n_done, n_err, o_pixel_count);
      end
   endtask

   task automatic test_bad_start();
      build_frame(2, 1'b0, '0);
      frm[1] = 8'h5C;
      run_frame();
      n_checks++;
      if (obs_addr.size() != 0 || n_err !== 1 || n_done !== 0) begin
         n_fail++; $display("FAIL bad_start writes=%0d err=%0d done=%0d want 0/1/0", obs_addr.size(), n_err, n_done);
      end
   endtask

   task automatic test_stop_in_data();
      build_frame(1, 1'b1, 24'hAAAAAA);
      run_frame();
      n_checks++;
      if (obs_data.size() != 1 || obs_data[0] !== 24'hAAAAAA || n_done !== 1 || n_err !== 0) begin
         n_fail++; $display("FAIL stop_data writes=%0d done=%0d err=%0d", obs_data.size(), n_done, n_err);
      end
      frm = '{8'h55, 8'h5B, 8'h11, 8'h22, 8'hAA, 8'hAA};
      run_frame();
      n_checks++;
      if (obs_data.size() != 0 || n_done !== 0 || n_err !== 1 || o_pixel_count !== 1) begin
         n_fail++; $display("FAIL misaligned writes=%0d done=%0d err=%0d count=%0d", obs_data.size(), n_done, n_err, o_pixel_count);
      end
   endtask

   task automatic test_abort_bits();
      build_frame(1, 1'b1, 24'h123456);
      frm.pop_back(); frm.pop_back();
      if (CK != 0) void'(frm.pop_back());
      clear_obs();
      frame_open();
      frame_send();
      send_bits(8'hAA, 5);
      frame_close();
      n_checks++;
      if (n_err !== 1 || n_done !== 0) begin
         n_fail++; $display("FAIL abort_bits err=%0d done=%0d want 1/0", n_err, n_done);
      end
   endtask

   task automatic test_mid_reset();
      build_frame(3, 1'b0, '0);
      clear_obs();
      frame_open();
      for (int k = 0; k < 8; k++) send_bits(frm[k], 8);
      send_bits(frm[8], 3);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({o_wr_en, o_busy, o_frame_done, o_frame_err} !== 4'b0 || o_pixel_count !== '0) begin
         n_fail++; $display("FAIL midrst_outputs flags=%b count=%0d want 0", {o_wr_en, o_busy, o_frame_done, o_frame_err}, o_pixel_count);
      end
      @(negedge clk);
      rst = 1'b0;
      exp_count = '0;
      clear_obs();
      send_bits(frm[8], 5);
      for (int k = 9; k < frm.size(); k++) send_bits(frm[k], 8);
      frame_close();
      n_checks++;
      if (obs_addr.size() != 0 || n_done !== 0 || n_err !== 0 || o_busy !== 1'b0) begin
         n_fail++; $display("FAIL midrst_quiet writes=%0d done=%0d err=%0d busy=%b", obs_addr.size(), n_done, n_err, o_busy);
      end
      build_frame(2, 1'b0, '0);
      run_frame();
      n_checks++;
      if (wr_diff() !== -1 || n_done !== 1 || n_err !== 0 || o_pixel_count !== 2) begin
         n_fail++; $display("FAIL midrst_next diff=%0d done=%0d err=%0d count=%0d", wr_diff(), n_done, n_err, o_pixel_count);
      end
   endtask

`ifdef SPI_PIX_CHECKSUM_EN
   task automatic test_checksum();
      build_frame(2, 1'b0, '0);
      frm[frm.size()-3] = frm[frm.size()-3] ^ 8'h01;
      run_frame();
      n_checks++;
      if (n_err !== 1 || n_done !== 0 || o_pixel_count !== 2) begin
         n_fail++; $display("FAIL checksum err=%0d done=%0d count=%0d", n_err, n_done, o_pixel_count);
      end
   endtask
`endif

   task automatic test_random();
      int npix, mode, pos;
      for (int f = 0; f < 8; f++) begin
         npix = $urandom_range(MAXP + 1, 0);
         mode = $urandom_range(4, 0);
         build_frame(npix, 1'b0, '0);
         case (mode)
            1: begin
               pos = $urandom_range(frm.size() - 3, 2);
               frm.delete(pos);
            end
            2: frm[frm.size()-1] = 8'hAB;
            3: frm[$urandom_range(1, 0)] = 8'h5C;
            4: if (CK != 0) frm[frm.size()-3] = frm[frm.size()-3] ^ 8'h80;
            default: ;
         endcase
         run_frame();
         n_checks++;
         if (wr_diff() !== -1) begin
            n_fail++; $display("FAIL rand%0d_writes mode=%0d npix=%0d got=%0d want=%0d", f, mode, npix, obs_addr.size(), exp_addr.size());
         end
         n_checks++;
         if (n_done !== exp_done || n_err !== exp_err || o_pixel_count !== exp_count) begin
            n_fail++;
            $display("FAIL rand%0d_result mode=%0d done=%0d/%0d err=%0d/%0d count=%0d/%0d",
                     f, mode, n_done, exp_done, n_err, exp_err, o_pixel_count, exp_count);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_overflow();
      test_bad_start();
      test_stop_in_data();
      test_abort_bits();
      test_mid_reset();
`ifdef SPI_PIX_CHECKSUM_EN
      test_checksum();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
